// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-way round-robin arbiter, registered held grant, ack release.
// Optional grant watchdog is built when RR_ARBITER_N_TIMEOUT_EN is defined.
module rr_arbiter_n #(
  parameter int N = 4,
  parameter int TIMEOUT = 16,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_an,
  input  logic [N-1:0]   req,
  input  logic           ack,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_vld,
  output logic           timeout
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;
  logic [N-1:0]   r_grant;
  logic [N-1:0]   w_grant_nx;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] w_id_nx;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_nx;
  logic [IDW-1:0] w_nxt;
  logic [IDW-1:0] w_base;
  logic [IDW-1:0] w_off;
  logic [IDW-1:0] w_win;
  logic [IDW:0]   w_sum;
  logic [IDW:0]   w_wrap;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_onehot;
  logic           w_any;
  logic           w_rel;
  logic           w_exp;
  logic           r_to;
  logic           w_to_nx;

  assign w_any  = |req;
  assign w_nxt  = (r_id == IDW'(N - 1)) ? '0 : r_id + IDW'(1);
  assign w_rel  = (r_state == S_GRANT) && (ack || !req[r_id] || w_exp);
  assign w_base = w_rel ? w_nxt : r_ptr;

  // Rotate so the pointer position lands on bit 0; wrap is modulo N.
  assign w_rot = N'({req, req} >> w_base);

  always_comb begin
    w_off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = IDW'(j);
    end
  end

  assign w_sum    = {1'b0, w_base} + {1'b0, w_off};
  assign w_wrap   = w_sum - (IDW + 1)'(N);
  assign w_win    = (w_sum >= (IDW + 1)'(N)) ? w_wrap[IDW-1:0]
                                             : w_sum[IDW-1:0];
  assign w_onehot = {{(N - 1){1'b0}}, 1'b1} << w_win;

`ifdef RR_ARBITER_N_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;

  // An ack or abandon on the expiry edge wins over the revoke.
  assign w_exp = (r_state == S_GRANT) && (r_cnt == CW'(TIMEOUT - 1))
              && !ack && req[r_id];

  always_comb begin
    w_cnt_nx = r_cnt;
    if (r_state == S_GRANT) w_cnt_nx = w_rel ? '0 : r_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) r_cnt <= '0;
    else         r_cnt <= w_cnt_nx;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 1);
  assign w_exp = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_id_nx    = r_id;
    w_ptr_nx   = r_ptr;
    w_to_nx    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nx = S_GRANT;
          w_grant_nx = w_onehot;
          w_id_nx    = w_win;
        end
      end
      S_GRANT: begin
        if (w_rel) begin
          w_ptr_nx = w_nxt;
          w_to_nx  = w_exp;
          if (w_any) begin
            w_grant_nx = w_onehot;
            w_id_nx    = w_win;
          end else begin
            w_state_nx = S_IDLE;
            w_grant_nx = '0;
            w_id_nx    = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_id    <= w_id_nx;
      r_ptr   <= w_ptr_nx;
      r_to    <= w_to_nx;
    end
  end

  assign grant     = r_grant;
  assign grant_id  = r_id;
  assign grant_vld = (r_state == S_GRANT);
  assign timeout   = r_to;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n: N=5 arbiter against a behavioural round-robin model,
// directed scenarios with literal expectations, then random req/ack traffic.
module tb_rr_arbiter_n;
  localparam int N   = 5;
  localparam int TO  = 4;
  localparam int IDW = $clog2(N);
`ifdef RR_ARBITER_N_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_an = 1'b0;
  logic           ack = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_vld;
  logic           timeout;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter_n #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_an(rst_an),
    .req(req),
    .ack(ack),
    .grant(grant),
    .grant_id(grant_id),
    .grant_vld(grant_vld),
    .timeout(timeout)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: who holds the grant, for how many visible cycles, and the pointer.
  int m_ptr, m_gid, m_age;
  bit m_vld, m_to;
  logic m_exp, m_rel;
  int m_np;

  function automatic int winner(logic [N-1:0] r, int base);
    for (int k = 0; k < N; k++)
      if (r[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  assign m_exp = WD && m_vld && (m_age == TO) && !ack && req[m_gid];
  assign m_rel = m_vld && (ack || !req[m_gid] || m_exp);
  assign m_np  = (m_gid + 1) % N;

  always @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      m_vld <= 1'b0; m_gid <= 0; m_ptr <= 0; m_age <= 0; m_to <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (!m_vld) begin
        if (req != 0) begin
          m_vld <= 1'b1; m_gid <= winner(req, m_ptr); m_age <= 1;
        end
      end else if (m_rel) begin
        m_ptr <= m_np;
        m_to  <= m_exp;
        if (req != 0) begin
          m_gid <= winner(req, m_np); m_age <= 1;
        end else begin
          m_vld <= 1'b0; m_gid <= 0; m_age <= 0;
        end
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  logic [N-1:0] one = 1;
  always @(negedge clk) begin
    if (run) begin
      chk("m_grant", grant, m_vld ? (one << m_gid) : '0);
      chk("m_id", grant_id, m_vld ? m_gid : 0);
      chk("m_vld", grant_vld, m_vld);
      chk("m_timeout", timeout, m_to);
    end
  end

  int exp_fair[5] = '{0, 1, 2, 3, 0};
  int exp_np2[3] = '{4, 0, 4};

  initial begin
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_id", grant_id, 0);
    chk("rst_vld", grant_vld, 0);
    chk("rst_to", timeout, 0);
    @(negedge clk); rst_an = 1'b1; run = 1'b1;

    req = 5'b01111; ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("fair_id", grant_id, exp_fair[i]);
      chk("fair_vld", grant_vld, 1);
    end

    @(negedge clk); req = '0; ack = 1'b0;
    @(negedge clk); req = 5'b01000;
    @(negedge clk); req = 5'b10001; ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("np2_id", grant_id, exp_np2[i]);
    end
    @(negedge clk); req = '0; ack = 1'b0;
    @(posedge clk); #2;
    chk("idle_vld", grant_vld, 0);
    chk("idle_grant", grant, 0);

    @(negedge clk); req = 5'b00010;
    @(posedge clk); #2;
    chk("hold_first", grant, 5'b00010);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); req = (i < 5) ? 5'b01111 : 5'b11110;
    end
`ifndef RR_ARBITER_N_TIMEOUT_EN
    @(posedge clk); #2;
    chk("hold_grant", grant, 5'b00010);
    @(negedge clk); req = 5'b11101;
    @(posedge clk); #2;
    chk("hold_drop", grant, 5'b00100);
`else
    @(negedge clk); req = '0;
    @(negedge clk); req = 5'b00001;
    @(posedge clk); #2;
    chk("wd_grant", grant, 5'b00001);
    chk("wd_to0", timeout, 0);
    repeat (3) @(posedge clk);
    @(posedge clk); #2;
    chk("wd_to1", timeout, 1);
    chk("wd_regrant", grant, 5'b00001);
    @(negedge clk); req = 5'b00011;
    chk("wd_pulse", timeout, 1);
    @(posedge clk); #2;
    chk("wd_to_end", timeout, 0);
    repeat (2) @(posedge clk);
    @(posedge clk); #2;
    chk("wd_next", grant, 5'b00010);
    chk("wd_to2", timeout, 1);
`endif

    @(negedge clk); req = '0; ack = 1'b0;
    @(negedge clk); req = '0;
    @(negedge clk); req = 5'b01000;
    @(posedge clk); #2;
    chk("ar_grant", grant, 5'b01000);
    #1 rst_an = 1'b0;
    #1;
    chk("ar_grant0", grant, 0);
    chk("ar_vld0", grant_vld, 0);
    chk("ar_id0", grant_id, 0);
    @(negedge clk); rst_an = 1'b1; req = 5'b01001;
    @(posedge clk); #2;
    chk("ar_ptr", grant, 5'b00001);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) req = N'($urandom_range(0, (1 << N) - 1));
      ack = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk); run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
